// File: rtl/csl23bit_sub_seq.sv
// Sequential WIDTH-bit subtractor: diff = A - B - bin, resolving CHUNK bits of the borrow chain per clock.
// Optional signed-overflow flag port `ovf` is built only when SUB_OVF_FLAG_EN is defined.
module csl23bit_sub_seq #(
    parameter int WIDTH = 23,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             BOUT,
    output logic             zero
`ifdef SUB_OVF_FLAG_EN
    ,
    output logic             ovf
`endif
);

    localparam int NCHUNK = (WIDTH + CHUNK - 1) / CHUNK;
    localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [KW-1:0] KLAST = KW'(NCHUNK - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state_q, state_nxt;
    logic               in_ready_q, in_ready_nxt;
    logic               out_valid_q, out_valid_nxt;
    logic [WIDTH-1:0]   a_q, b_q;
    logic               brw_q, brw_nxt;
    logic [KW-1:0]      k_q;
    logic [WIDTH-1:0]   diff_q, diff_nxt;
    logic               bout_q, zero_q;
    logic [CHUNK-1:0]   a_sl, b_sl;
    logic [CHUNK:0]     res;
    logic [WIDTH-1:0]   ins, msk;
    int                 base, nbits;

    // Ripple subtract over the low nbits of a chunk; the returned MSB is the
    // borrow out of the last valid bit, so a clipped final chunk stays exact.
    function automatic logic [CHUNK:0] sub_chunk(
        input logic [CHUNK-1:0] a,
        input logic [CHUNK-1:0] b,
        input logic             bi,
        input int               nb
    );
        logic [CHUNK-1:0] d;
        logic             br;
        d  = '0;
        br = bi;
        for (int i = 0; i < CHUNK; i++) begin
            if (i < nb) begin
                d[i] = a[i] ^ b[i] ^ br;
                br   = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & br);
            end
        end
        return {br, d};
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_nxt;
    end

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            IDLE:    if (in_valid && in_ready_q) state_nxt = RUN;
            RUN:     if (k_q == KLAST)           state_nxt = DONE;
            DONE:    if (out_ready)              state_nxt = IDLE;
            default:                             state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready_nxt  = (state_nxt == IDLE);
        out_valid_nxt = (state_nxt == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            in_ready_q  <= in_ready_nxt;
            out_valid_q <= out_valid_nxt;
        end
    end

    // Current chunk: slices beyond bit WIDTH-1 shift out of the mask and are never written.
    always_comb begin
        base     = int'(k_q) * CHUNK;
        nbits    = ((WIDTH - base) < CHUNK) ? (WIDTH - base) : CHUNK;
        a_sl     = CHUNK'(a_q >> base);
        b_sl     = CHUNK'(b_q >> base);
        res      = sub_chunk(a_sl, b_sl, brw_q, nbits);
        ins      = WIDTH'(res[CHUNK-1:0]) << base;
        msk      = WIDTH'({CHUNK{1'b1}}) << base;
        diff_nxt = (diff_q & ~msk) | (ins & msk);
        brw_nxt  = res[CHUNK];
    end

`ifdef SUB_OVF_FLAG_EN
    logic ovf_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            brw_q  <= 1'b0;
            k_q    <= '0;
            diff_q <= '0;
            bout_q <= 1'b0;
            zero_q <= 1'b0;
`ifdef SUB_OVF_FLAG_EN
            ovf_q  <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid && in_ready_q) begin
                        a_q   <= A;
                        b_q   <= B;
                        brw_q <= bin;
                        k_q   <= '0;
                    end
                end
                RUN: begin
                    diff_q <= diff_nxt;
                    brw_q  <= brw_nxt;
                    if (k_q == KLAST) begin
                        bout_q <= brw_nxt;
                        zero_q <= (diff_nxt == '0);
`ifdef SUB_OVF_FLAG_EN
                        ovf_q  <= (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                                  (diff_nxt[WIDTH-1] != a_q[WIDTH-1]);
`endif
                    end else begin
                        k_q <= k_q + KW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign diff      = diff_q;
    assign BOUT      = bout_q;
    assign zero      = zero_q;
`ifdef SUB_OVF_FLAG_EN
    assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_csl23bit_sub_seq.sv
// Directed bench for csl23bit_sub_seq at default parameters (WIDTH=23, CHUNK=4, latency 6).
// Define SUB_OVF_FLAG_EN for both files to also exercise the ovf port.
module tb_csl23bit_sub_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [22:0] A, B;
    logic        bin;
    logic        out_valid;
    logic        out_ready;
    logic [22:0] diff;
    logic        BOUT;
    logic        zero;
`ifdef SUB_OVF_FLAG_EN
    logic        ovf;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    csl23bit_sub_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .BOUT      (BOUT),
        .zero      (zero)
`ifdef SUB_OVF_FLAG_EN
        ,
        .ovf       (ovf)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_out(input string tag);
        int lat;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_latency"}, lat, 6);
    endtask

    task automatic run_op(input string tag, input logic [22:0] a, input logic [22:0] b,
                          input logic bi, input logic [22:0] ed, input logic eb,
                          input logic ez, input logic eo);
        @(negedge clk);
        check({tag, "_in_ready_pre"}, in_ready, 1);
        A = a; B = b; bin = bi; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        A = ~a; B = ~b; bin = ~bi;
        wait_out(tag);
        check({tag, "_diff"}, diff, ed);
        check({tag, "_bout"}, BOUT, eb);
        check({tag, "_zero"}, zero, ez);
`ifdef SUB_OVF_FLAG_EN
        check({tag, "_ovf"}, ovf, eo);
`endif
        @(posedge clk); #1;
        check({tag, "_out_valid_drop"}, out_valid, 0);
        check({tag, "_in_ready_post"}, in_ready, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        A = '0; B = '0; bin = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_diff", diff, 0);
        check("rst_bout", BOUT, 0);
        check("rst_zero", zero, 0);
`ifdef SUB_OVF_FLAG_EN
        check("rst_ovf", ovf, 0);
`endif
        rst_n = 1'b1;

        run_op("basic",   23'd100,      23'd1,        1'b0, 23'd99,       1'b0, 1'b0, 1'b0);
        run_op("under1",  23'd0,        23'd1,        1'b0, 23'h7FFFFF,   1'b1, 1'b0, 1'b0);
        run_op("under2",  23'd0,        23'h7FFFFF,   1'b1, 23'h000000,   1'b1, 1'b1, 1'b0);
        run_op("equal",   23'h5A5A5A,   23'h5A5A5A,   1'b0, 23'h000000,   1'b0, 1'b1, 1'b0);
        run_op("xchunk",  23'h000010,   23'h000001,   1'b0, 23'h00000F,   1'b0, 1'b0, 1'b0);
        run_op("ovf_pos", 23'h3FFFFF,   23'h7FFFFF,   1'b0, 23'h400000,   1'b1, 1'b0, 1'b1);
        run_op("ovf_neg", 23'd5,        23'd3,        1'b0, 23'd2,        1'b0, 1'b0, 1'b0);

        // Back-pressure, with the next operands presented (in_valid high) throughout.
        @(negedge clk);
        A = 23'h123456; B = 23'h023456; bin = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        A = 23'd9; B = 23'd2; bin = 1'b0;
        wait_out("bp");
        check("bp_diff", diff, 23'h0FFFFF);
        check("bp_bout", BOUT, 0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp_hold_valid", out_valid, 1);
            check("bp_hold_diff", diff, 23'h0FFFFF);
            check("bp_hold_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_valid", out_valid, 0);
        check("bp_release_in_ready", in_ready, 1);
        @(posedge clk); #1;
        check("bp_next_accepted", in_ready, 0);
        in_valid = 1'b0;
        wait_out("bp_next");
        check("bp_next_diff", diff, 23'd7);
        check("bp_next_bout", BOUT, 0);
        @(posedge clk); #1;
        check("bp_next_drop", out_valid, 0);

        // Abort mid-RUN: reset lands while chunk 3 is pending.
        @(negedge clk);
        A = 23'h400000; B = 23'd1; bin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", out_valid, 0);
        check("abort_diff", diff, 0);
        check("abort_in_ready", in_ready, 1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        begin
            logic seen;
            seen = 1'b0;
            for (int i = 0; i < 8; i++) begin
                @(posedge clk); #1;
                if (out_valid) seen = 1'b1;
            end
            check("abort_no_pulse", seen, 0);
        end
        run_op("after_rst", 23'd7, 23'd3, 1'b0, 23'd4, 1'b0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
